// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared video timing definitions for the retro video pipeline (terminal, tile
// and sprite renderers, sync generator).
//   - default timing constants for a 256x240 NTSC-like raster
//   - helper functions that derive the sync window and counter limits
//   - the 9-bit beam position type used on every position bus
// -----------------------------------------------------------------------------
package video_timing_pkg;

   // Beam positions are 9 bits wide; every derived limit must fit below this.
   localparam int POS_W     = 9;
   localparam int POS_LIMIT = 1 << POS_W;

   typedef logic [POS_W-1:0] pos_t;

   // Default horizontal timing (clocks).
   localparam int H_DISPLAY_DEF = 256;
   localparam int H_BACK_DEF    = 23;
   localparam int H_FRONT_DEF   = 7;
   localparam int H_SYNC_DEF    = 23;

   // Default vertical timing (lines).
   localparam int V_DISPLAY_DEF = 240;
   localparam int V_TOP_DEF     = 5;
   localparam int V_BOTTOM_DEF  = 14;
   localparam int V_SYNC_DEF    = 3;

   // The sync pulse starts right after the visible area plus the trailing
   // border (right border horizontally, bottom border vertically).
   function automatic int sync_start(input int display, input int trailing);
      return display + trailing;
   endfunction

   // Last position (inclusive) at which the sync pulse is requested.
   function automatic int sync_end(input int start, input int width);
      return start + width - 1;
   endfunction

   // Last position of a line/frame; the counter wraps to 0 after it.
   function automatic int pos_max(input int display, input int leading,
                                  input int trailing, input int width);
      return display + leading + trailing + width - 1;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Up-counter that returns to zero after reaching MAX.
//   clk    in   clock
//   reset  in   asynchronous, active-high reset (count -> 0)
//   en     in   advance the count on this edge
//   count  out  current count, 0..MAX
//   wrap   out  high in the cycle where an enabled edge takes MAX back to 0
// -----------------------------------------------------------------------------
module wrap_counter #(
   parameter int WIDTH = 9,
   parameter int MAX   = 308
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             at_max;

   assign at_max = (count_q == MAX_V);
   assign wrap   = en && at_max;
   assign count  = count_q;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = at_max ? '0 : count_q + ONE_V;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/hvsync_generator.sv
// -----------------------------------------------------------------------------
// hvsync_generator
// Free-running raster timing generator: beam position counters, registered
// horizontal/vertical sync pulses and a display-active flag.
//   clk         in   pixel clock
//   reset       in   asynchronous, active-high reset
//   hsync       out  horizontal sync (registered, polarity per SYNC_ACTIVE_HIGH)
//   vsync       out  vertical sync (registered, polarity per SYNC_ACTIVE_HIGH)
//   display_on  out  high while hpos/vpos lie inside the visible area
//   hpos        out  horizontal position, 0..H_MAX
//   vpos        out  vertical position, 0..V_MAX
// -----------------------------------------------------------------------------
module hvsync_generator
   import video_timing_pkg::*;
#(
   parameter int H_DISPLAY        = H_DISPLAY_DEF,
   parameter int H_BACK           = H_BACK_DEF,
   parameter int H_FRONT          = H_FRONT_DEF,
   parameter int H_SYNC           = H_SYNC_DEF,
   parameter int V_DISPLAY        = V_DISPLAY_DEF,
   parameter int V_TOP            = V_TOP_DEF,
   parameter int V_BOTTOM         = V_BOTTOM_DEF,
   parameter int V_SYNC           = V_SYNC_DEF,
   parameter int SYNC_ACTIVE_HIGH = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [8:0] hpos,
   output logic [8:0] vpos
);

   localparam int H_SYNC_START = sync_start(H_DISPLAY, H_FRONT);
   localparam int H_SYNC_END   = sync_end(H_SYNC_START, H_SYNC);
   localparam int H_MAX        = pos_max(H_DISPLAY, H_BACK, H_FRONT, H_SYNC);
   localparam int V_SYNC_START = sync_start(V_DISPLAY, V_BOTTOM);
   localparam int V_SYNC_END   = sync_end(V_SYNC_START, V_SYNC);
   localparam int V_MAX        = pos_max(V_DISPLAY, V_TOP, V_BOTTOM, V_SYNC);

   // Limits must be representable in the 9-bit position buses.
   generate
      if (H_MAX >= POS_LIMIT || V_MAX >= POS_LIMIT) begin : g_bad_timing
         $error("hvsync_generator: H_MAX=%0d / V_MAX=%0d exceed the 9-bit position range",
                H_MAX, V_MAX);
      end
   endgenerate

   localparam pos_t H_DISPLAY_P    = pos_t'(H_DISPLAY);
   localparam pos_t V_DISPLAY_P    = pos_t'(V_DISPLAY);
   localparam pos_t H_SYNC_START_P = pos_t'(H_SYNC_START);
   localparam pos_t H_SYNC_END_P   = pos_t'(H_SYNC_END);
   localparam pos_t V_SYNC_START_P = pos_t'(V_SYNC_START);
   localparam pos_t V_SYNC_END_P   = pos_t'(V_SYNC_END);

   localparam logic SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
   localparam logic SYNC_OFF = ~SYNC_ON;

   logic h_wrap;
   logic frame_wrap_unused;
   logic hsync_q;
   logic hsync_d;
   logic vsync_q;
   logic vsync_d;

   // Horizontal counter runs every clock; the vertical one advances only on
   // the line wrap, so frame wrap and line wrap land on the same edge.
   wrap_counter #(
      .WIDTH (POS_W),
      .MAX   (H_MAX)
   ) u_hcount (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .count (hpos),
      .wrap  (h_wrap)
   );

   wrap_counter #(
      .WIDTH (POS_W),
      .MAX   (V_MAX)
   ) u_vcount (
      .clk   (clk),
      .reset (reset),
      .en    (h_wrap),
      .count (vpos),
      .wrap  (frame_wrap_unused)
   );

   // Sync is decoded from the pre-increment position and registered, so the
   // pulse appears one clock after the position enters the sync window.
   // Downstream timing relies on this one-clock lag.
   always_comb begin
      hsync_d = SYNC_OFF;
      vsync_d = SYNC_OFF;
      if (hpos >= H_SYNC_START_P && hpos <= H_SYNC_END_P) begin
         hsync_d = SYNC_ON;
      end
      if (vpos >= V_SYNC_START_P && vpos <= V_SYNC_END_P) begin
         vsync_d = SYNC_ON;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_q <= SYNC_OFF;
         vsync_q <= SYNC_OFF;
      end else begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign display_on = (hpos < H_DISPLAY_P) && (vpos < V_DISPLAY_P);

endmodule

// File: tb/tb_hvsync_generator.sv
// -----------------------------------------------------------------------------
// tb_hvsync_generator
// Self-checking bench for hvsync_generator. Two instances share clock and
// reset: one with active-high sync, one with active-low sync. Every clock the
// expected beam state (derived arithmetically from the number of edges since
// reset) is queued and compared against both instances; a table of named
// checkpoints covers the line/frame boundaries, and hand-written sequences
// cover whole-frame pulse counts and an asynchronous mid-line reset.
// -----------------------------------------------------------------------------
module tb_hvsync_generator;

   localparam int HTOT = 309;
   localparam int VTOT = 262;
   localparam int FRAME = HTOT * VTOT;  // 80958

   logic       clk;
   logic       reset;
   logic       hsync_hi, vsync_hi, de_hi;
   logic [8:0] hpos_hi, vpos_hi;
   logic       hsync_lo, vsync_lo, de_lo;
   logic [8:0] hpos_lo, vpos_lo;

   hvsync_generator u_dut_hi (
      .clk        (clk),
      .reset      (reset),
      .hsync      (hsync_hi),
      .vsync      (vsync_hi),
      .display_on (de_hi),
      .hpos       (hpos_hi),
      .vpos       (vpos_hi)
   );

   hvsync_generator #(.SYNC_ACTIVE_HIGH(0)) u_dut_lo (
      .clk        (clk),
      .reset      (reset),
      .hsync      (hsync_lo),
      .vsync      (vsync_lo),
      .display_on (de_lo),
      .hpos       (hpos_lo),
      .vpos       (vpos_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [8:0]  h;
      logic [8:0]  v;
      logic        hs;
      logic        vs;
      logic        de;
   } vec_t;

   typedef struct {
      logic [8:0] h;
      logic [8:0] v;
      logic       hs;
      logic       vs;
      logic       de;
   } exp_t;

   int          compared   = 0;
   int          mismatched = 0;
   int unsigned n          = 0;
   exp_t        sb_q[$];
   vec_t        tbl[18];

   // aggregates over the first full frame (n = 0 .. FRAME-1)
   int          hs_cnt = 0;
   int          vs_cnt = 0;
   int          de_cnt = 0;
   int          max_h  = 0;
   int          run_len = 0;
   int          first_run = -1;
   bit          phase1 = 1'b1;

   function automatic exp_t model(input int unsigned k);
      exp_t        e;
      int unsigned ph, pv;
      e.h  = 9'(k % HTOT);
      e.v  = 9'((k / HTOT) % VTOT);
      e.de = (e.h < 256) && (e.v < 240);
      e.hs = 1'b0;
      e.vs = 1'b0;
      if (k != 0) begin
         ph   = (k - 1) % HTOT;
         pv   = ((k - 1) / HTOT) % VTOT;
         e.hs = (ph >= 263) && (ph <= 285);
         e.vs = (pv >= 254) && (pv <= 256);
      end
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, req);
      end
   endtask

   // Pop the queued expectation for this cycle and check both instances.
   task automatic check_cycle();
      exp_t e;
      if (sb_q.size() == 0) begin
         cmp("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      cmp("cyc_hi", {11'd0, hpos_hi, vpos_hi, hsync_hi, vsync_hi, de_hi},
                    {11'd0, e.h, e.v, e.hs, e.vs, e.de});
      cmp("cyc_lo", {11'd0, hpos_lo, vpos_lo, hsync_lo, vsync_lo, de_lo},
                    {11'd0, e.h, e.v, ~e.hs, ~e.vs, e.de});
      if (int'(hpos_hi) > max_h) max_h = int'(hpos_hi);
      if (phase1 && n < FRAME) begin
         if (hsync_hi) hs_cnt++;
         if (vsync_hi) vs_cnt++;
         if (de_hi)    de_cnt++;
         if (n < HTOT) begin
            if (hsync_hi) begin
               if (run_len == 0) first_run = int'(hpos_hi);
               run_len++;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      n++;
      sb_q.push_back(model(n));
      @(negedge clk);
      check_cycle();
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      sb_q.push_back(model(0));
      check_cycle();
   endtask

   initial begin
      //          cyc     h    v   hs vs de
      tbl[0]  = '{0,      0,   0,  0, 0, 1};
      tbl[1]  = '{1,      1,   0,  0, 0, 1};
      tbl[2]  = '{255,    255, 0,  0, 0, 1};
      tbl[3]  = '{256,    256, 0,  0, 0, 0};
      tbl[4]  = '{263,    263, 0,  0, 0, 0};
      tbl[5]  = '{264,    264, 0,  1, 0, 0};
      tbl[6]  = '{286,    286, 0,  1, 0, 0};
      tbl[7]  = '{287,    287, 0,  0, 0, 0};
      tbl[8]  = '{308,    308, 0,  0, 0, 0};
      tbl[9]  = '{309,    0,   1,  0, 0, 1};
      tbl[10] = '{74160,  0,   240, 0, 0, 0};
      tbl[11] = '{78486,  0,   254, 0, 0, 0};
      tbl[12] = '{78487,  1,   254, 0, 1, 0};
      tbl[13] = '{79413,  0,   257, 0, 1, 0};
      tbl[14] = '{79414,  1,   257, 0, 0, 0};
      tbl[15] = '{80957,  308, 261, 0, 0, 0};
      tbl[16] = '{80958,  0,   0,  0, 0, 1};
      tbl[17] = '{81417,  150, 1,  0, 0, 1};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      release_reset();

      for (int i = 0; i < 18; i++) begin
         while (n < tbl[i].cyc) step();
         cmp("tbl_h",  {23'd0, hpos_hi},  {23'd0, tbl[i].h});
         cmp("tbl_v",  {23'd0, vpos_hi},  {23'd0, tbl[i].v});
         cmp("tbl_hs", {31'd0, hsync_hi}, {31'd0, tbl[i].hs});
         cmp("tbl_vs", {31'd0, vsync_hi}, {31'd0, tbl[i].vs});
         cmp("tbl_de", {31'd0, de_hi},    {31'd0, tbl[i].de});
         $display("vector %0d: n=%0d h=%0d v=%0d hs=%b vs=%b de=%b", i, n,
                  hpos_hi, vpos_hi, hsync_hi, vsync_hi, de_hi);
      end

      // whole-frame pulse and visible-area counts
      cmp("hsync_run_len",   run_len,   23);
      cmp("hsync_run_first", first_run, 264);
      cmp("hsync_frame_cnt", hs_cnt,    23 * VTOT);
      cmp("vsync_frame_cnt", vs_cnt,    3 * HTOT);
      cmp("display_cnt",     de_cnt,    256 * 240);
      cmp("max_hpos",        max_h,     308);
      $display("frame: hs=%0d vs=%0d de=%0d max_h=%0d", hs_cnt, vs_cnt, de_cnt, max_h);

      // asynchronous reset between edges, mid-line (hpos=150, vpos=1)
      phase1 = 1'b0;
      #2 reset = 1'b1;
      #1;
      cmp("async_hi", {12'd0, hpos_hi, vpos_hi, hsync_hi, vsync_hi},
                      {12'd0, 9'd0, 9'd0, 1'b0, 1'b0});
      cmp("async_lo", {12'd0, hpos_lo, vpos_lo, hsync_lo, vsync_lo},
                      {12'd0, 9'd0, 9'd0, 1'b1, 1'b1});
      $display("async reset: h=%0d v=%0d hs_hi=%b vs_hi=%b hs_lo=%b vs_lo=%b",
               hpos_hi, vpos_hi, hsync_hi, vsync_hi, hsync_lo, vsync_lo);
      repeat (2) @(posedge clk);
      release_reset();
      repeat (320) step();
      cmp("restart_h", {23'd0, hpos_hi}, 32'd11);
      cmp("restart_v", {23'd0, vpos_hi}, 32'd1);
      $display("restart: n=%0d h=%0d v=%0d", n, hpos_hi, vpos_hi);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
